uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver: the receive-side counterpart of uart_tx, using the same 8N1 framing (start bit, 8 data bits LSB first, 1 stop bit, idle high).
- Synchronises the asynchronous serial line, detects start bits and samples each bit at mid-bit.
- Presents each received byte with a one-cycle done strobe and flags framing errors.
- Sits between the board RX pin and the byte-level consumer logic; loopback-tested against uart_tx.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in bits/s
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE, derived localparam: clock cycles per bit (must be >= 4)

Ports:
iClk  input  1  system clock, rising edge
iRstN  input  1  asynchronous active-low reset
iRxSerial  input  1  asynchronous serial line, idle high
oRxByte  output  8  last correctly received byte; held until the next good frame
oRxDone  output  1  one-cycle pulse: oRxByte updated this cycle
oRxBusy  output  1  high while a frame is being received (any state other than IDLE)
oFrameErr  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (iRstN=0, async): state=IDLE; both synchroniser flops=1; counters=0; shift register=0.
- Reset outputs: oRxByte=8'h00, oRxDone=0, oRxBusy=0, oFrameErr=0.
- Reset mid-frame aborts the frame silently: no done pulse, no error pulse.
- Input path: 2-flop synchroniser on iRxSerial; the FSM uses only the second flop (rxSync).
- Counters: bit-period counter wide enough for CLKS_PER_BIT-1; 3-bit bit index.
- IDLE: when rxSync==0, go to START with the counter cleared.
- START: count to CLKS_PER_BIT/2-1 (integer division), i.e. mid-start-bit.
  - rxSync still 0 there: go to DATA, clear counter and bit index.
  - rxSync 1 there: false start; return to IDLE with no pulses.
- DATA: count to CLKS_PER_BIT-1, then sample rxSync into the shift register MSB while shifting right (LSB-first assembly).
  - Clear the counter after each sample.
  - After bit index 7 is sampled, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - Sample 1: oRxByte<=shift register, oRxDone=1 for exactly one cycle.
  - Sample 0: oFrameErr=1 for exactly one cycle; oRxByte unchanged.
  - Either way return to IDLE in the same cycle. Leaving at mid-stop-bit lets a back-to-back start bit be caught.
- oRxDone and oFrameErr are registered, mutually exclusive, and never high in consecutive cycles.
- Latency: oRxDone rises 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2..4 cycles after iRxSerial falls. With CLKS_PER_BIT=10 that is cycles 97..99.
- iRxSerial activity during DATA/STOP has no effect except through the samples.
- A line held low (break) produces one oFrameErr, then a new frame restarts immediately from IDLE.

Optional Feature:
Macro: UART_RX_MAJORITY_EN.
- Defined: each data/stop sample is the 2-of-3 majority of rxSync at counter values CLKS_PER_BIT-2, CLKS_PER_BIT-1 and CLKS_PER_BIT-3 (three consecutive cycles ending at the sample point).
  - The START check likewise uses the majority around its mid point.
  - A single-cycle glitch at the sample point is rejected.
  - Latency unchanged.
- Undefined: single sample of rxSync at the sample point; the majority logic is absent.
- Ports identical in both builds.

Test Plan:
- Loopback: uart_tx → uart_rx, CLK_FREQ=100, BAUD_RATE=10, send 8'h56 → exactly one oRxDone, oRxByte=8'h56, oFrameErr never high, oRxBusy falls within 1 cycle of oRxDone.
- Back-to-back: uart_tx sends 8'hA5 then 8'h3C with no idle gap → two oRxDone pulses ~100 cycles apart; oRxByte=8'hA5 then 8'h3C.
- False start: drive iRxSerial low for 3 cycles then high (CLKS_PER_BIT=10) → state returns to IDLE; no oRxDone, no oFrameErr; oRxByte unchanged.
- Framing error: bit-bang 8'hFF with a 0 stop bit → one oFrameErr pulse, no oRxDone, oRxByte keeps its previous value (8'h56).
- Reset mid-frame: assert iRstN=0 during data bit 4 of an 8'h81 frame, release, then send 8'h42 → no pulse for 8'h81; oRxByte=8'h00 after reset, then 8'h42 with one oRxDone.
- UART_RX_MAJORITY_EN defined: inject a 1-cycle inverted glitch at the sample point of every data bit of 8'h5A → oRxByte=8'h5A. Without the macro the same stimulus gives 8'hA5.

Source files
------------

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- signal bundle between the board RX pin, the UART receiver and
// the byte-level consumer.
//
// Signals:
//   iRxSerial  serial line, asynchronous, idle high
//   oRxByte    last correctly received byte, held until the next good frame
//   oRxDone    one-cycle strobe: oRxByte was updated this cycle
//   oRxBusy    high while a frame is being received
//   oFrameErr  one-cycle strobe: stop bit was sampled low
//   dbg_state  receiver FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: oRxDone is a valid-only strobe. There is no ready and no
// backpressure; the consumer must take oRxByte in the cycle oRxDone is high
// or later, until the next oRxDone replaces it.
//
// Modports:
//   master  the receiver (drives the byte-side outputs)
//   slave   the pin driver / consumer side
// ---------------------------------------------------------------------------
interface uart_rx_if;
  logic       iRxSerial;
  logic [7:0] oRxByte;
  logic       oRxDone;
  logic       oRxBusy;
  logic       oFrameErr;
  logic [1:0] dbg_state;

  modport master (
    input  iRxSerial,
    output oRxByte, oRxDone, oRxBusy, oFrameErr, dbg_state
  );

  modport slave (
    output iRxSerial,
    input  oRxByte, oRxDone, oRxBusy, oFrameErr, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver (start bit, 8 data bits LSB first, 1 stop bit,
// idle high). Synchronises the serial line, qualifies the start bit at its
// middle, samples each data bit and the stop bit at mid-bit, and presents
// each good byte with a one-cycle done strobe. A low stop bit produces a
// one-cycle frame-error strobe instead and leaves the held byte untouched.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  serial bit rate in bits/s
//   (CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, must be >= 4)
//
// Ports:
//   iClk   system clock, rising edge
//   iRstN  asynchronous active-low reset
//   rx_if  uart_rx_if.master: iRxSerial in; oRxByte, oRxDone, oRxBusy,
//          oFrameErr, dbg_state out
//
// Optional build macro: UART_RX_MAJORITY_EN
//   Defined: every start/data/stop decision is the 2-of-3 majority of the
//   synchronised line over the three cycles ending at the sample point, so a
//   single-cycle glitch at the sample point is rejected. Latency unchanged.
//   Undefined: single sample at the sample point.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic     iClk,
  input  logic     iRstN,
  uart_rx_if.master rx_if
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Registers
  logic             r_sync1;
  logic             r_sync2;    // rxSync: the only view of the line the FSM uses
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_done;
  logic             r_err;

  // Next-state wires
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_byte_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_sample;

  // Two-flop synchroniser; resets to the idle (high) line level so that
  // leaving reset never looks like a start bit.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_if.iRxSerial;
      r_sync2 <= r_sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // History of rxSync for the two cycles before the current one. At the
  // sample point these hold the values seen at counts LAST-2 and LAST-1
  // (MID-2 and MID-1 for the start check).
  logic [1:0] r_hist;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
    end
  end

  assign w_sample = (r_hist[1] & r_hist[0]) |
                    (r_hist[1] & r_sync2)   |
                    (r_hist[0] & r_sync2);
`else
  assign w_sample = r_sync2;
`endif

  // FSM state and datapath registers
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state   <= S_IDLE;
      r_cnt     <= CNT_ZERO;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_byte    <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_byte    <= w_byte_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_nxt    = r_byte;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_ZERO;
        end
      end

      S_START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt = CNT_ZERO;
          if (!w_sample) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            // Line went back high before mid-start: a glitch, not a frame.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          // LSB arrives first, so shifting right leaves it in bit 0 at the end.
          w_shift_nxt = {w_sample, r_shift[7:1]};
          w_cnt_nxt   = CNT_ZERO;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          // Return to IDLE at mid-stop-bit so a back-to-back start edge is
          // seen in time.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
          if (w_sample) begin
            w_byte_nxt = r_shift;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign rx_if.oRxByte   = r_byte;
  assign rx_if.oRxDone   = r_done;
  assign rx_if.oFrameErr = r_err;
  assign rx_if.oRxBusy   = (r_state != S_IDLE);
  assign rx_if.dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx with CLK_FREQ=100, BAUD_RATE=10
// (10 clocks per bit). The serial line is bit-banged from tasks; a negedge
// monitor records strobes, received bytes and their cycle numbers.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLK_FREQ (100),
    .BAUD_RATE(10)
  ) dut (
    .iClk (clk),
    .iRstN(rst_n),
    .rx_if(rx_if)
  );

  // Scoreboard state
  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  int done_cnt    = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int t_done      = 0;
  int t_done_prev = 0;
  int t_busy_fall = 0;
  int t_fall      = 0;
  logic prev_busy  = 1'b0;
  logic prev_pulse = 1'b0;

  // Monitor: samples outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_if.oRxDone) begin
      done_cnt++;
      got_q.push_back(rx_if.oRxByte);
      t_done_prev = t_done;
      t_done      = cyc;
    end
    if (rx_if.oFrameErr) err_cnt++;
    if ((rx_if.oRxDone && rx_if.oFrameErr) ||
        (prev_pulse && (rx_if.oRxDone || rx_if.oFrameErr)))
      overlap_cnt++;
    if (prev_busy && !rx_if.oRxBusy) t_busy_fall = cyc;
    prev_busy  = rx_if.oRxBusy;
    prev_pulse = rx_if.oRxDone || rx_if.oFrameErr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks. All line changes happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_if.iRxSerial = b;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    t_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  // Each data bit carries a one-cycle inverted pulse placed so that it is the
  // value captured at the receiver's sample point for that bit.
  task automatic send_glitched(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx_if.iRxSerial = d[i];
      tick(5);
      rx_if.iRxSerial = ~d[i];
      tick(1);
      rx_if.iRxSerial = d[i];
      tick(4);
    end
    drive_bit(1'b1);
  endtask

  int base_done;
  int base_err;
  logic [7:0] glitch_exp;

  initial begin
    rx_if.iRxSerial = 1'b1;
    rst_n = 1'b0;
    tick(3);

    // Reset state
    check("reset_byte", 32'(rx_if.oRxByte), 32'h00);
    check("reset_done", 32'(rx_if.oRxDone), 32'h0);
    check("reset_busy", 32'(rx_if.oRxBusy), 32'h0);
    check("reset_ferr", 32'(rx_if.oFrameErr), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // Single frame 8'h56
    base_done = done_cnt;
    base_err  = err_cnt;
    send_frame(8'h56, 1'b1);
    tick(10);
    check("lb_done_count", 32'(done_cnt - base_done), 32'd1);
    check("lb_byte", 32'(rx_if.oRxByte), 32'h56);
    check("lb_ferr_count", 32'(err_cnt - base_err), 32'd0);
    check("lb_latency", 32'(t_done - t_fall), 32'd98);
    check("lb_busy_fall", 32'((t_busy_fall - t_done) <= 1 && t_busy_fall >= t_done), 32'd1);
    check("lb_q_byte", 32'(got_q[got_q.size()-1]), 32'h56);

    // False start: 3 low cycles then high
    base_done = done_cnt;
    base_err  = err_cnt;
    rx_if.iRxSerial = 1'b0;
    tick(3);
    rx_if.iRxSerial = 1'b1;
    tick(20);
    check("fs_done_count", 32'(done_cnt - base_done), 32'd0);
    check("fs_ferr_count", 32'(err_cnt - base_err), 32'd0);
    check("fs_byte", 32'(rx_if.oRxByte), 32'h56);
    check("fs_state_idle", 32'(rx_if.dbg_state), 32'd0);

    // Framing error: 8'hFF with a low stop bit
    base_done = done_cnt;
    base_err  = err_cnt;
    send_frame(8'hFF, 1'b0);
    rx_if.iRxSerial = 1'b1;
    tick(30);
    check("fe_ferr_count", 32'(err_cnt - base_err), 32'd1);
    check("fe_done_count", 32'(done_cnt - base_done), 32'd0);
    check("fe_byte", 32'(rx_if.oRxByte), 32'h56);
    check("fe_busy", 32'(rx_if.oRxBusy), 32'd0);

    // Back-to-back frames, no idle gap
    base_done = done_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(10);
    check("b2b_done_count", 32'(done_cnt - base_done), 32'd2);
    check("b2b_first", 32'(got_q[got_q.size()-2]), 32'hA5);
    check("b2b_second", 32'(got_q[got_q.size()-1]), 32'h3C);
    check("b2b_gap", 32'(t_done - t_done_prev), 32'd100);

    // Reset during data bit 4 of 8'h81
    base_done = done_cnt;
    base_err  = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h81 >> i) & 1));
    rx_if.iRxSerial = 1'b0;
    tick(5);
    rst_n = 1'b0;
    rx_if.iRxSerial = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(150);
    check("rst_byte", 32'(rx_if.oRxByte), 32'h00);
    check("rst_done_count", 32'(done_cnt - base_done), 32'd0);
    check("rst_ferr_count", 32'(err_cnt - base_err), 32'd0);
    send_frame(8'h42, 1'b1);
    tick(10);
    check("rst_next_byte", 32'(rx_if.oRxByte), 32'h42);
    check("rst_next_done", 32'(done_cnt - base_done), 32'd1);

    // Glitch at every data sample point of 8'h5A
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h5A;
`else
    glitch_exp = 8'hA5;
`endif
    base_done = done_cnt;
    send_glitched(8'h5A);
    tick(10);
    check("gl_done_count", 32'(done_cnt - base_done), 32'd1);
    check("gl_byte", 32'(rx_if.oRxByte), 32'(glitch_exp));

    // Strobes were never simultaneous nor in consecutive cycles
    check("pulse_overlap", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
